// File: rtl/traffic_light_ctrl_pkg.sv
// traffic_light_ctrl_pkg: shared state encodings, lamp constants and sizing helper
package traffic_light_ctrl_pkg;
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } state_t;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/tick_detect.sv
// tick_detect: one-cycle pulse on each rising edge of a slow data-clock
module tick_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic slow_clk,
  output logic tick
);
  logic slow_q, slow_d;
  always_comb slow_d = slow_clk;
  always_ff @(posedge clock_in)
    if (reset) slow_q <= slow_clk;
    else slow_q <= slow_d;
  assign tick = slow_clk & ~slow_q;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road signal controller with pedestrian walk phase
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int RED_TICKS    = 1,
  parameter int WALK_TICKS   = 4,
  parameter int MIN_GREEN    = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       ped_request,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state_code
);
  localparam int MAXD = max4(GREEN_TICKS, YELLOW_TICKS, RED_TICKS, WALK_TICKS);
  localparam int EW = $clog2(MAXD) + 1;
  localparam logic [EW-1:0] GRN_L  = EW'(GREEN_TICKS - 1);
  localparam logic [EW-1:0] YEL_L  = EW'(YELLOW_TICKS - 1);
  localparam logic [EW-1:0] RED_L  = EW'(RED_TICKS - 1);
  localparam logic [EW-1:0] WALK_L = EW'(WALK_TICKS - 1);
  localparam logic [EW-1:0] MING_L = EW'(MIN_GREEN - 1);
  state_t state_q, state_d, next_state;
  logic [EW-1:0] elapsed_q, elapsed_d, limit;
  logic ped_pending_q, ped_pending_d, walk_active_q, walk_active_d;
  logic tick, is_grn, is_yel, all_red, advance, enter_red;
  tick_detect u_tick (
    .clock_in(clock_in),
    .reset   (reset),
    .slow_clk(slow_clk),
    .tick    (tick)
  );
  always_comb begin
    is_grn = state_q == NS_GREEN || state_q == EW_GREEN;
    is_yel = state_q == NS_YELLOW || state_q == EW_YELLOW;
    all_red = state_q == ALL_RED_1 || state_q == ALL_RED_2;
    limit = is_grn ? GRN_L : is_yel ? YEL_L : walk_active_q ? WALK_L : RED_L;
    // illegal codes advance unconditionally so they recover without waiting for a tick
    advance = !(is_grn || is_yel || all_red) ||
              (tick && (elapsed_q == limit || (is_grn && ped_pending_q && elapsed_q >= MING_L)));
    next_state = (state_q == ALL_RED_2 || !(is_grn || is_yel || all_red)) ? NS_GREEN
               : state_t'(state_q + 3'd1);
    enter_red = advance && (next_state == ALL_RED_1 || next_state == ALL_RED_2);
    state_d = advance ? next_state : state_q;
    elapsed_d = advance ? '0 : tick ? elapsed_q + 1'b1 : elapsed_q;
    ped_pending_d = enter_red ? ped_request : ped_pending_q | ped_request;
    walk_active_d = enter_red ? ped_pending_q : (advance && all_red) ? 1'b0 : walk_active_q;
  end
  always_ff @(posedge clock_in)
    if (reset) begin
      state_q <= NS_GREEN;
      elapsed_q <= '0;
      ped_pending_q <= 1'b0;
      walk_active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elapsed_q <= elapsed_d;
      ped_pending_q <= ped_pending_d;
      walk_active_q <= walk_active_d;
    end
  always_comb begin
    ns_light = state_q == NS_GREEN ? LAMP_GRN : state_q == NS_YELLOW ? LAMP_YEL : LAMP_RED;
    ew_light = state_q == EW_GREEN ? LAMP_GRN : state_q == EW_YELLOW ? LAMP_YEL : LAMP_RED;
    walk = walk_active_q;
    state_code = state_q;
  end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed checks of phase timing, walk service, reset and recovery
module tb_traffic_light_ctrl;
  import traffic_light_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, slow_clk, ped_request;
  logic [2:0] ns_light, ew_light, state_code;
  logic walk;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  traffic_light_ctrl dut (
    .clock_in   (clk),
    .reset      (rst),
    .slow_clk   (slow_clk),
    .ped_request(ped_request),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .state_code (state_code)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (mon_en)
      check("lamp_safe", int'($onehot(ns_light) && $onehot(ew_light) &&
            (ns_light == 3'b100 || ew_light == 3'b100)), 1);
  task automatic do_tick();
    @(negedge clk) slow_clk = 1'b1;
    @(negedge clk) slow_clk = 1'b0;
  endtask
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask
  task automatic do_reset();
    @(negedge clk) begin rst = 1'b1; slow_clk = 1'b0; ped_request = 1'b0; end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic check_state(input string tag, input int st, input int ns, input int ew, input int w);
    check({tag, "_state"}, state_code, st);
    check({tag, "_ns"}, ns_light, ns);
    check({tag, "_ew"}, ew_light, ew);
    check({tag, "_walk"}, walk, w);
  endtask
  initial begin
    rst = 1'b1;
    slow_clk = 1'b0;
    ped_request = 1'b0;
    do_reset();
    mon_en = 1'b1;
    check_state("reset", 0, 1, 4, 0);
    run_ticks(7);  check_state("free_t7", 0, 1, 4, 0);
    run_ticks(1);  check_state("free_t8", 1, 2, 4, 0);
    run_ticks(2);  check_state("free_t10", 2, 4, 4, 0);
    run_ticks(1);  check_state("free_t11", 3, 4, 1, 0);
    run_ticks(7);  check("free_t18_state", state_code, 3);
    run_ticks(1);  check_state("free_t19", 4, 4, 2, 0);
    run_ticks(2);  check_state("free_t21", 5, 4, 4, 0);
    run_ticks(1);  check_state("free_t22", 0, 1, 4, 0);
    check("hold_pre_elapsed", dut.elapsed_q, 0);
    @(negedge clk) slow_clk = 1'b1;
    repeat (10) @(negedge clk);
    slow_clk = 1'b0;
    @(negedge clk);
    check("hold_elapsed", dut.elapsed_q, 1);
    check("hold_state", state_code, 0);
    do_reset();
    @(negedge clk) ped_request = 1'b1;
    @(negedge clk) ped_request = 1'b0;
    check("ped_pending_set", dut.ped_pending_q, 1);
    run_ticks(2);  check("ped_t2_state", state_code, 0);
    run_ticks(1);  check_state("ped_t3", 1, 2, 4, 0);
    run_ticks(2);  check_state("ped_t5", 2, 4, 4, 1);
    run_ticks(3);  check_state("ped_t8", 2, 4, 4, 1);
    run_ticks(1);  check_state("ped_t9", 3, 4, 1, 0);
    do_reset();
    run_ticks(9);  check("entry_t9_state", state_code, 1);
    @(negedge clk) begin slow_clk = 1'b1; ped_request = 1'b1; end
    @(negedge clk) begin slow_clk = 1'b0; ped_request = 1'b0; end
    check_state("entry_t10", 2, 4, 4, 0);
    check("entry_pending", dut.ped_pending_q, 1);
    run_ticks(1);  check_state("entry_t11", 3, 4, 1, 0);
    run_ticks(3);  check("entry_t14_state", state_code, 4);
    run_ticks(2);  check_state("entry_t16", 5, 4, 4, 1);
    run_ticks(3);  check_state("entry_t19", 5, 4, 4, 1);
    run_ticks(1);  check_state("entry_t20", 0, 1, 4, 0);
    do_reset();
    run_ticks(19); check("mid_t19_state", state_code, 4);
    @(negedge clk) ped_request = 1'b1;
    @(negedge clk) begin rst = 1'b1; slow_clk = 1'b1; end
    @(negedge clk) begin rst = 1'b0; ped_request = 1'b0; end
    check_state("mid_reset", 0, 1, 4, 0);
    check("mid_reset_pending", dut.ped_pending_q, 0);
    @(negedge clk);
    check("no_spurious_elapsed", dut.elapsed_q, 0);
    check("no_spurious_state", state_code, 0);
    slow_clk = 1'b0;
    run_ticks(3);  check("force_pre_state", state_code, 0);
    @(negedge clk) force dut.state_q = state_t'(3'd6);
    #1 release dut.state_q;
    check("forced_code", state_code, 6);
    @(negedge clk);
    check_state("forced_recover", 0, 1, 4, 0);
    check("forced_elapsed", dut.elapsed_q, 0);
    @(negedge clk) mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
